// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative 32-bit restoring divider for MIPS DIV/DIVU in the
//                EX stage. Produces {HI = remainder, LO = quotient} after a
//                fixed 32-step sequence. Raises a stall request while busy
//                and can be cancelled by annul.
//
//  Ports
//    clk         in   1   system clock, rising edge
//    rst         in   1   synchronous active-high reset
//    start       in   1   division request, held until ready
//    signed_div  in   1   1 = DIV (two's complement), 0 = DIVU
//    opdata1     in   32  dividend, sampled on acceptance only
//    opdata2     in   32  divisor, sampled on acceptance only
//    annul       in   1   cancel requested / in-flight division
//    result      out  64  {remainder, quotient}, valid while ready
//    ready       out  1   one-cycle completion pulse
//    stallreq    out  1   pipeline stall request
//
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DIVZERO = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;

    // r_quot starts as |dividend| and is shifted left each step, so quotient
    // bits enter at the bottom while dividend bits leave at the top.
    logic [31:0] r_quot;
    logic [32:0] r_rem;
    logic [31:0] r_divisor;
    logic [4:0]  r_count;
    logic        r_quot_neg;
    logic        r_rem_neg;
    logic [63:0] r_result;

    logic        w_accept;
    logic        w_sign1;
    logic        w_sign2;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [33:0] w_shifted;
    logic [33:0] w_trial;
    logic        w_fits;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quot_nxt;
    logic        w_last;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // ------------------------------------------------------------------
    // Operand conditioning. Negation is modulo 2^32, so 0x80000000 maps to
    // itself and is then treated as an unsigned magnitude.
    // ------------------------------------------------------------------
    assign w_accept = start & ~annul;
    assign w_sign1  = signed_div & opdata1[31];
    assign w_sign2  = signed_div & opdata2[31];
    assign w_abs1   = w_sign1 ? (32'd0 - opdata1) : opdata1;
    assign w_abs2   = w_sign2 ? (32'd0 - opdata2) : opdata2;

    // ------------------------------------------------------------------
    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value stays below 2^33; a 34-bit subtract therefore
    // exposes the borrow in bit 33.
    // ------------------------------------------------------------------
    assign w_shifted  = {r_rem, r_quot[31]};
    assign w_trial    = w_shifted - {2'b00, r_divisor};
    assign w_fits     = ~w_trial[33];
    assign w_rem_nxt  = w_fits ? w_trial[32:0] : w_shifted[32:0];
    assign w_quot_nxt = {r_quot[30:0], w_fits};
    assign w_last     = (r_count == c_LAST_STEP);

    // Sign flags are only ever set for signed divisions, so unsigned results
    // pass through untouched. Remainder takes the dividend's sign.
    assign w_quot_fix = r_quot_neg ? (32'd0 - w_quot_nxt) : w_quot_nxt;
    assign w_rem_fix  = r_rem_neg ? (32'd0 - w_rem_nxt[31:0]) : w_rem_nxt[31:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and stall request
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        stallreq    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stallreq    = 1'b1;
                    w_state_nxt = (opdata2 == 32'd0) ? S_DIVZERO : S_BUSY;
                end
            end
            S_BUSY: begin
                stallreq = 1'b1;
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DIVZERO: begin
                stallreq    = 1'b1;
                w_state_nxt = annul ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                // Stall drops here so the pipeline advances with the result.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. The result is captured on the transition into
    // DONE so it is already valid during the ready cycle, and it holds
    // until the next completion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot     <= 32'd0;
            r_rem      <= 33'd0;
            r_divisor  <= 32'd0;
            r_count    <= 5'd0;
            r_quot_neg <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_result   <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quot     <= w_abs1;
                        r_divisor  <= w_abs2;
                        r_rem      <= 33'd0;
                        r_count    <= 5'd0;
                        r_quot_neg <= w_sign1 ^ w_sign2;
                        r_rem_neg  <= w_sign1;
                    end
                end
                S_BUSY: begin
                    if (!annul) begin
                        r_rem   <= w_rem_nxt;
                        r_quot  <= w_quot_nxt;
                        r_count <= r_count + 5'd1;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                        end
                    end
                end
                S_DIVZERO: begin
                    // Architecturally undefined; defined here as all zeros.
                    if (!annul) begin
                        r_result <= 64'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign ready  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit. Expected results come
//                from a 64-bit reference model and are queued when a
//                division is started; a monitor pops and compares them on
//                every ready pulse. Directed loops check stall/ready timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int          n_checks;
    int          n_fails;
    logic [63:0] sb_q[$];

    div_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: 64-bit signed arithmetic cannot overflow for 32-bit
    // operands, and SV '/' and '%' truncate toward zero like MIPS.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            la = $signed(a);
            lb = $signed(b);
        end else begin
            la = {32'd0, a};
            lb = {32'd0, b};
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Every ready pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (ready) begin
            if (sb_q.size() == 0) begin
                check("ready_unexpected", {63'd0, ready}, 64'd0);
            end else begin
                check("result", result, sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one division at cycle T and follow it to the ready cycle,
    // checking stallreq/ready every cycle, then return one cycle later (IDLE).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        sb_q.push_back(model(sgn, a, b));
        start      = 1'b1;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        #1;
        check("stall_T", {63'd0, stallreq}, 64'd1);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k < lat) begin
                check("stall_busy", {63'd0, stallreq}, 64'd1);
                check("ready_early", {63'd0, ready}, 64'd0);
            end else begin
                check("ready_pulse", {63'd0, ready}, 64'd1);
                check("stall_done", {63'd0, stallreq}, 64'd0);
                start = 1'b0;
            end
        end
        step();
        check("ready_after", {63'd0, ready}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        annul      = 1'b0;
        step();
        step();
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", {63'd0, stallreq}, 64'd0);
        rst = 1'b0;
        step();

        // Directed operands
        run_div(1'b0, 32'd7, 32'd2);
        check("divu_7_2_held", result, 64'h00000001_00000003);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        check("div_min_neg1", result, 64'h00000000_80000000);
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1);
        run_div(1'b1, 32'd5, 32'd0);
        check("divzero_result", result, 64'd0);

        // Random operands
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd3 : $urandom >> (i * 3);
            rs = i[0];
            run_div(rs, ra, rb);
        end

        // Annul at T+10, restart at T+12, ready at T+45
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd7;
        for (int k = 1; k <= 10; k++) step();
        annul = 1'b1;
        #1;
        check("annul_stall_T10", {63'd0, stallreq}, 64'd1);
        step();
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("annul_stall_T11", {63'd0, stallreq}, 64'd0);
        check("annul_ready_T11", {63'd0, ready}, 64'd0);
        step();
        run_div(1'b1, 32'hFFFF0000, 32'd9);

        // Reset in the middle of a busy division
        start      = 1'b1;
        signed_div = 1'b1;
        opdata1    = 32'd12345;
        opdata2    = 32'd11;
        for (int k = 1; k <= 20; k++) step();
        rst   = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_stall", {63'd0, stallreq}, 64'd0);

        // start and annul together in IDLE: nothing accepted
        start = 1'b1;
        annul = 1'b1;
        #1;
        check("start_annul_stall", {63'd0, stallreq}, 64'd0);
        step();
        start = 1'b0;
        annul = 1'b0;
        #1;
        check("start_annul_next", {63'd0, stallreq}, 64'd0);
        for (int k = 0; k < 36; k++) step();

        // Back to normal operation after reset/annul
        run_div(1'b0, 32'd100, 32'd10);
        check("scoreboard_drained", {32'd0, sb_q.size()}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Iterative 32-bit MIPS divider (DIV/DIVU) in the EX stage, the producer of the HI/LO values that EX forwards to ID and later writes into the register file's HI/LO registers. It accepts a dividend/divisor pair and produces quotient (LO) and remainder (HI) after a fixed number of cycles. While it is busy it raises a stall request that freezes the pipeline, and it supports cancellation when the instruction is annulled.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; held high by EX until `ready` is seen
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1  input  32  dividend; sampled only when a division is accepted
- opdata2  input  32  divisor; sampled only when a division is accepted
- annul  input  1  cancel in-flight or requested division (flush)
- result  output  64  {HI = remainder, LO = quotient}; valid when `ready`=1
- ready  output  1  result valid; high exactly one cycle per completed division
- stallreq  output  1  pipeline stall request to the hazard/stall controller

## Operation
- Reset and power-up state: IDLE, ready=0, result=0, stallreq=0, counter=0, internal registers cleared.
- States: IDLE, BUSY, DIVZERO, DONE.
- IDLE:
  - If start=1 and annul=0 and opdata2=0, latch sign information and go to DIVZERO.
  - If start=1 and annul=0 and opdata2≠0, latch |opdata1| and |opdata2| (absolute values only when signed_div=1), record quotient sign = sign1 XOR sign2 and remainder sign = sign1, clear the 33-bit partial remainder and counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: one restoring-division step per cycle.
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor from the 33-bit partial remainder. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the remainder and shift in 0.
  - Increment the counter. After the step taken with counter=31, go to DONE.
- DIVZERO: go to DONE with quotient=0 and remainder=0. MIPS leaves the value undefined; we define it as 0.
- DONE:
  - result = {remainder negated if remainder sign=1, quotient negated if quotient sign=1}; sign correction is applied only when signed_div=1.
  - ready=1 for this cycle only; next state is IDLE.
  - result holds its value after DONE until the next DONE or reset.
- Arithmetic rules:
  - Absolute values are taken modulo 2^32, so |0x80000000| = 0x80000000 as unsigned.
  - 0x80000000 / 0xFFFFFFFF signed yields LO=0x80000000, HI=0. No trap.
- annul:
  - In BUSY or DIVZERO: next state is IDLE, with no DONE and no ready pulse.
  - In IDLE: the division is not accepted.
  - In DONE: ready still pulses and the state goes to IDLE; the consumer discards the result.
- rst overrides everything, including mid-BUSY: the next state is IDLE with all outputs at their reset values.
- Simultaneous start and annul: annul wins.

## Timing
- stallreq = (IDLE & start & ~annul) | BUSY | DIVZERO. It is combinational from state and inputs, and 0 in DONE so the pipeline advances on the ready cycle.
- Nonzero divisor, start sampled high in cycle T: BUSY during T+1..T+32, ready=1 in cycle T+33.
- Zero divisor: DIVZERO in T+1, ready=1 in T+2.
- EX keeps start, signed_div and the operands stable while stallreq=1. Operands are not re-sampled after acceptance.
- After ready, the earliest new acceptance is the cycle after DONE, i.e. back-to-back divisions are separated by one IDLE cycle.
- `result` is registered. `ready` is a registered state decode, not combinational from inputs.

## Test plan
- Unsigned: DIVU 7/2, start at T → stallreq high T..T+32, ready only at T+33, result HI=0x00000001, LO=0x00000003.
- Signed: DIV 0xFFFFFFF9 (−7) / 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD. Also 7 / 0xFFFFFFFE → HI=1, LO=0xFFFFFFFD.
- Edge operands:
  - DIV 0x80000000 / 0xFFFFFFFF → HI=0, LO=0x80000000.
  - DIVU 0xFFFFFFFF / 1 → HI=0, LO=0xFFFFFFFF.
- Divide by zero: DIV 5/0 → ready at T+2, result 0, stallreq high only T..T+1.
- annul asserted in cycle T+10 of a busy division → IDLE at T+11, no ready pulse, stallreq low from T+11. A new division started at T+12 completes correctly at T+45.
- rst asserted in cycle T+20 of a busy division → next cycle IDLE, ready=0, result=0, stallreq=0. start+annul in the same IDLE cycle → no acceptance, stallreq=0.
